// File: rtl/nexi_uart_rx_sampler_if.sv
// Byte-delivery handshake between the UART rx sampler (master) and the RBR load path (slave).
interface nexi_uart_rx_sampler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_ready_o;
    logic                  frame_err_o;
    logic                  parity_err_o;
    logic                  overrun_o;
    logic                  read_ack_i;

    modport master (
        output data_o, data_ready_o, frame_err_o, parity_err_o, overrun_o,
        input  read_ack_i
    );

    modport slave (
        input  data_o, data_ready_o, frame_err_o, parity_err_o, overrun_o,
        output read_ack_i
    );
endinterface

// File: rtl/nexi_uart_rx_sampler.sv
// 16x-oversampling UART receiver front end with majority-vote sampling and ready/ack delivery.
// Define NEXI_UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module nexi_uart_rx_sampler #(
    parameter int CLK_DIV     = 27,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_pin,
    nexi_uart_rx_sampler_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, fill_q;
    logic                    rx_s, rx_prev_q, armed_q, fall_edge;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [3:0]              os_cnt_q;
    logic                    tick, bit_done, bit_val;
    logic [2:0]              smp_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [IDX_W-1:0]        bit_idx_q;
    logic                    start_evt, shift_en, idx_clr, par_en, deliver_evt;
    logic                    new_ferr, new_perr, hold_new, do_deliver;
    logic [DATA_WIDTH-1:0]   data_q, pend_data_q, src_data;
    logic                    rdy_q, ferr_q, perr_q, ovr_q;
    logic                    pend_q, pend_ferr_q, pend_perr_q, src_ferr, src_perr;

    // Synchroniser; armed_q only sets once a genuinely sampled high level has been seen,
    // so a line held low across reset release cannot fake a start edge.
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign fall_edge = armed_q && rx_prev_q && !rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            fill_q    <= '0;
            rx_prev_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_pin};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            rx_prev_q <= rx_s;
            if (fill_q[SYNC_STAGES-1] && rx_s)
                armed_q <= 1'b1;
        end
    end

    assign tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign bit_done = tick && (os_cnt_q == 4'd15);
    assign bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
            smp_q     <= '0;
        end else begin
            if (start_evt) begin
                div_cnt_q <= '0;
                os_cnt_q  <= '0;
            end else if (tick) begin
                div_cnt_q <= '0;
                os_cnt_q  <= os_cnt_q + 4'd1;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            if (tick && (os_cnt_q >= 4'd7) && (os_cnt_q <= 4'd9))
                smp_q <= {smp_q[1:0], rx_s};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (fall_edge) state_d = ST_START;
            ST_START:  if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (bit_done && (bit_idx_q == IDX_W'(DATA_WIDTH - 1))) begin
`ifdef NEXI_UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            ST_PARITY: if (bit_done) state_d = ST_STOP;
            ST_STOP:   if (bit_done) state_d = bit_val ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_evt   = (state_q == ST_IDLE) && fall_edge;
        idx_clr     = (state_q == ST_START);
        shift_en    = (state_q == ST_DATA) && bit_done;
        par_en      = (state_q == ST_PARITY) && bit_done;
        deliver_evt = (state_q == ST_STOP) && bit_done;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            if (idx_clr)
                bit_idx_q <= '0;
            else if (shift_en)
                bit_idx_q <= bit_idx_q + IDX_W'(1);
            if (shift_en)
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
        end
    end

`ifdef NEXI_UART_RX_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       parity_q <= 1'b0;
        else if (par_en) parity_q <= bit_val;
    end
    assign new_perr = ^{shift_q, parity_q};
`else
    assign new_perr = 1'b0;
`endif

    // A byte finishing while the consumer still holds ack from the previous byte is parked
    // in the pending buffer until ack drops; a newer byte replaces anything parked.
    assign new_ferr   = ~bit_val;
    assign hold_new   = deliver_evt && bus.read_ack_i && !rdy_q;
    assign do_deliver = (deliver_evt && !hold_new) || (pend_q && !bus.read_ack_i);
    assign src_data   = deliver_evt ? shift_q  : pend_data_q;
    assign src_ferr   = deliver_evt ? new_ferr : pend_ferr_q;
    assign src_perr   = deliver_evt ? new_perr : pend_perr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q      <= '0;
            rdy_q       <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_ferr_q <= 1'b0;
            pend_perr_q <= 1'b0;
        end else begin
            ovr_q <= do_deliver && rdy_q;
            if (hold_new) begin
                pend_q      <= 1'b1;
                pend_data_q <= shift_q;
                pend_ferr_q <= new_ferr;
                pend_perr_q <= new_perr;
            end else if (do_deliver) begin
                pend_q <= 1'b0;
            end
            if (do_deliver) begin
                data_q <= src_data;
                ferr_q <= src_ferr;
                perr_q <= src_perr;
                rdy_q  <= 1'b1;
            end else if (bus.read_ack_i) begin
                rdy_q  <= 1'b0;
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_ready_o = rdy_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.parity_err_o = perr_q;
    assign bus.overrun_o    = ovr_q;
endmodule

// File: tb/tb_nexi_uart_rx_sampler.sv
// Scoreboard bench for nexi_uart_rx_sampler: frames are serialised onto rx_pin, expectations queued.
module tb_nexi_uart_rx_sampler;
    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_pin = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ovr_seen = 0;
    logic rdy_prev = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    nexi_uart_rx_sampler_if #(.DATA_WIDTH(8)) bus ();

    nexi_uart_rx_sampler #(
        .CLK_DIV(CLK_DIV), .DATA_WIDTH(8), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_pin(rx_pin), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: a delivery is a rising data_ready_o or an overrun pulse (overwrite while ready).
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            if (bus.overrun_o) ovr_seen++;
            if ((bus.data_ready_o && !rdy_prev) || bus.overrun_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_delivery", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("data", {24'd0, bus.data_o}, {24'd0, e.d});
                    chk("frame_err", {31'd0, bus.frame_err_o}, {31'd0, e.fe});
                    chk("parity_err", {31'd0, bus.parity_err_o}, {31'd0, e.pe});
                    chk("overrun", {31'd0, bus.overrun_o}, {31'd0, e.ov});
                end
            end
            rdy_prev = bus.data_ready_o;
        end
    end

    task automatic send_bit(input logic b);
        rx_pin = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input logic exp_ovr);
        exp_t e;
        logic pe;
        pe = par_flip;
`ifndef NEXI_UART_RX_PARITY_EN
        pe = 1'b0;
`endif
        e.d = d; e.fe = ~stop_b; e.pe = pe; e.ov = exp_ovr;
        sb_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef NEXI_UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk(tag, sb_q.size(), 32'd0);
    endtask

    task automatic ack_byte();
        @(negedge clk);
        bus.read_ack_i = 1'b1;
        @(negedge clk);
        bus.read_ack_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.read_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, bus.data_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.data_ready_o}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        chk("rst_perr", {31'd0, bus.parity_err_o}, 32'd0);
        chk("rst_ovr", {31'd0, bus.overrun_o}, 32'd0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);

        // Basic frame and single-cycle ack
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        wait_drain("t1_drain");
        chk("t1_ready", {31'd0, bus.data_ready_o}, 32'd1);
        chk("t1_ovr_cnt", ovr_seen, 32'd0);
        @(negedge clk);
        bus.read_ack_i = 1'b1;
        @(negedge clk);
        bus.read_ack_i = 1'b0;
        chk("t1_ack_clr", {31'd0, bus.data_ready_o}, 32'd0);

        // Short low glitch is rejected, then a real frame
        @(posedge clk);
        rx_pin = 1'b0;
        repeat (20) @(posedge clk);
        rx_pin = 1'b1;
        repeat (100) @(posedge clk);
        chk("t2_no_byte", {31'd0, bus.data_ready_o}, 32'd0);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        wait_drain("t2_drain");
        ack_byte();

        // Overrun
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        wait_drain("t3_drain_a");
        send_frame(8'hF0, 1'b1, 1'b0, 1'b1);
        wait_drain("t3_drain_b");
        chk("t3_ready", {31'd0, bus.data_ready_o}, 32'd1);
        chk("t3_data", {24'd0, bus.data_o}, 32'hF0);
        chk("t3_ovr_cnt", ovr_seen, 32'd1);
        chk("t3_ovr_pulse", {31'd0, bus.overrun_o}, 32'd0);
        ack_byte();

        // Framing error + break, then a byte held while ack stays high
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_pin = 1'b1;
        wait_drain("t4_drain_a");
        chk("t4_ferr", {31'd0, bus.frame_err_o}, 32'd1);
        repeat (BIT_CLKS) @(posedge clk);
        @(negedge clk);
        bus.read_ack_i = 1'b1;
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_held", {31'd0, bus.data_ready_o}, 32'd0);
        chk("t4_pending", sb_q.size(), 32'd1);
        bus.read_ack_i = 1'b0;
        wait_drain("t4_drain_b");
        chk("t4_ferr_clr", {31'd0, bus.frame_err_o}, 32'd0);

        // Reset mid-frame during the 4th data bit, line still low on release
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        repeat (BIT_CLKS / 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_data", {24'd0, bus.data_o}, 32'd0);
        chk("t6_ready", {31'd0, bus.data_ready_o}, 32'd0);
        chk("t6_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        chk("t6_perr", {31'd0, bus.parity_err_o}, 32'd0);
        chk("t6_ovr", {31'd0, bus.overrun_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        rx_pin = 1'b1;
        repeat (700) @(posedge clk);
        @(negedge clk);
        chk("t6_no_byte", {31'd0, bus.data_ready_o}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        wait_drain("t6_drain");
        chk("t6_data_after", {24'd0, bus.data_o}, 32'h3C);
        ack_byte();

`ifdef NEXI_UART_RX_PARITY_EN
        // Even parity: good bit, then a flipped one
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        wait_drain("t5_drain_a");
        chk("t5_perr_ok", {31'd0, bus.parity_err_o}, 32'd0);
        ack_byte();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_drain("t5_drain_b");
        chk("t5_perr_bad", {31'd0, bus.parity_err_o}, 32'd1);
        ack_byte();
`endif

        repeat (10) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
